data_mem_responder: RTL and testbench

Multi-cycle data-memory responder for the memory stage. It is the slave end of the memory stage's request interface (enable, wr, addr, data_in) and replaces the single-cycle memory model. Each request is held off with a stall for a fixed latency, then completed with a one-cycle done pulse. Read data is held until the next read completes. Misaligned word accesses are rejected with err.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the multi-cycle data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_LATENCY = 3;
   localparam int DEF_IDX_W   = 8;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, combinational read, async clear.
module dmem_array #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_widx,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_ridx,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**IDX_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**IDX_W; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_widx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage slave: stalls each request for LATENCY cycles, then pulses done.
// Misaligned requests skip the array and complete next cycle with err.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wr,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              stall,
   output logic              done,
   output logic              err
);

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_wr;
   logic              r_errPending;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_dataOut;
   logic [DATA_W-1:0] w_rdata;
   logic              w_access;
   logic              w_we;
   logic              w_accept;
   logic              w_unusedAddrHi;

   // Address bits above the word index wrap, so they are deliberately dropped.
   assign w_unusedAddrHi = ^addr[DATA_W-1:IDX_W+1];

   assign w_accept = (r_state == IDLE) && enable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_access = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_next = addr[0] ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == '0) begin
               w_next   = DONE;
               w_access = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_wr         <= 1'b0;
         r_errPending <= 1'b0;
         r_idx        <= '0;
         r_wdata      <= '0;
      end else if (w_accept) begin
         r_wr         <= wr;
         r_errPending <= addr[0];
         r_idx        <= addr[IDX_W:1];
         r_wdata      <= data_in;
         r_cnt        <= CNT_W'(LATENCY - 1);
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Loads land on the BUSY->DONE edge and hold until the next completed load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dataOut <= '0;
      end else if (w_access && !r_wr) begin
         r_dataOut <= w_rdata;
      end
   end

   assign w_we = w_access && r_wr;

   dmem_array #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_widx  (r_idx),
      .i_wdata (r_wdata),
      .i_ridx  (r_idx),
      .o_rdata (w_rdata)
   );

   assign stall    = !rst && (w_accept || (r_state == BUSY));
   assign done     = (r_state == DONE);
   assign err      = (r_state == DONE) && r_errPending;
   assign data_out = r_dataOut;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of data_mem_responder against a word-array model,
// using a LATENCY=3 instance and a LATENCY=1 instance on a shared clock.
module tb_data_mem_responder;

   localparam int DATA_W = 16;
   localparam int IDX_W  = 8;
   localparam int LAT0   = 3;
   localparam int LAT1   = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        enableL1;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] dataIn;
   logic [15:0] dataOut;
   logic [15:0] dataOutL1;
   logic        stall, done, err;
   logic        stallL1, doneL1, errL1;

   int testCount = 0;
   int failCount = 0;

   logic [15:0] modelMem [2][2**IDX_W];
   logic [15:0] modelOut [2];

   always #5 clk = ~clk;

   data_mem_responder #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LATENCY(LAT0)) dut (
      .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(dataIn),
      .data_out(dataOut), .stall(stall), .done(done), .err(err)
   );

   data_mem_responder #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LATENCY(LAT1)) dutL1 (
      .clk(clk), .rst(rst), .enable(enableL1), .wr(wr), .addr(addr), .data_in(dataIn),
      .data_out(dataOutL1), .stall(stallL1), .done(doneL1), .err(errL1)
   );

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int u = 0; u < 2; u++) begin
         modelOut[u] = '0;
         for (int j = 0; j < 2**IDX_W; j++) modelMem[u][j] = '0;
      end
   endtask

   // One complete request on the chosen instance; leaves enable high through DONE.
   task automatic applyStimulus(input int unit, input logic w, input logic [15:0] a,
                                input logic [15:0] d);
      int          busy;
      int          idx;
      logic        mis;
      logic [15:0] tmp;
      tmp  = a;
      mis  = tmp[0];
      idx  = int'(tmp[IDX_W:1]);
      busy = mis ? 0 : ((unit == 1) ? LAT1 : LAT0);
      @(negedge clk);
      wr = w; addr = a; dataIn = d;
      if (unit == 1) enableL1 = 1'b1; else enable = 1'b1;
      #1;
      checkOutput("stall_accept", (unit == 1) ? stallL1 : stall, 16'd1);
      checkOutput("done_accept", (unit == 1) ? doneL1 : done, 16'd0);
      for (int k = 0; k < busy; k++) begin
         @(negedge clk);
         wr = 1'($urandom); addr = 16'($urandom); dataIn = 16'($urandom);
         #1;
         checkOutput("stall_busy", (unit == 1) ? stallL1 : stall, 16'd1);
         checkOutput("done_busy", (unit == 1) ? doneL1 : done, 16'd0);
      end
      @(negedge clk);
      #1;
      if (!mis) begin
         if (w) modelMem[unit][idx] = d;
         else   modelOut[unit] = modelMem[unit][idx];
      end
      checkOutput("done_pulse", (unit == 1) ? doneL1 : done, 16'd1);
      checkOutput("err_pulse", (unit == 1) ? errL1 : err, {15'd0, mis});
      checkOutput("stall_done", (unit == 1) ? stallL1 : stall, 16'd0);
      checkOutput("data_out", (unit == 1) ? dataOutL1 : dataOut, modelOut[unit]);
   endtask

   task automatic goIdle();
      @(negedge clk);
      enable = 1'b0; enableL1 = 1'b0;
      #1;
      checkOutput("idle_stall", stall, 16'd0);
      checkOutput("idle_done", done, 16'd0);
      checkOutput("idle_data", dataOut, modelOut[0]);
   endtask

   initial begin
      logic [15:0] a;
      rst = 1'b1; enable = 1'b0; enableL1 = 1'b0; wr = 1'b0; addr = '0; dataIn = '0;
      modelReset();
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_stall", stall, 16'd0);
      checkOutput("rst_done", done, 16'd0);
      checkOutput("rst_err", err, 16'd0);
      checkOutput("rst_data", dataOut, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a store discards it.
      @(negedge clk);
      wr = 1'b1; addr = 16'h0010; dataIn = 16'h5555; enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_stall", stall, 16'd0);
      checkOutput("midrst_done", done, 16'd0);
      checkOutput("midrst_err", err, 16'd0);
      modelReset();
      @(negedge clk);
      rst = 1'b0; enable = 1'b0;
      #1;
      checkOutput("postrst_stall", stall, 16'd0);
      applyStimulus(0, 1'b0, 16'h0010, 16'h0000);
      goIdle();

      // Store then load, misaligned access, wrap-around.
      applyStimulus(0, 1'b1, 16'h0020, 16'hBEEF);
      goIdle();
      applyStimulus(0, 1'b0, 16'h0020, 16'h0000);
      goIdle();
      applyStimulus(0, 1'b0, 16'h0021, 16'h0000);
      goIdle();
      applyStimulus(0, 1'b1, 16'h0021, 16'hDEAD);
      goIdle();
      applyStimulus(0, 1'b0, 16'h0020, 16'h0000);
      goIdle();
      applyStimulus(0, 1'b1, 16'h0202, 16'h1234);
      goIdle();
      applyStimulus(0, 1'b0, 16'h0002, 16'h0000);

      // Enable held past DONE: the next IDLE cycle starts exactly one new request.
      applyStimulus(0, 1'b0, 16'h0020, 16'h0000);
      applyStimulus(0, 1'b0, 16'h0202, 16'h0000);
      goIdle();

      // LATENCY=1 instance.
      applyStimulus(1, 1'b1, 16'h0040, 16'hA5A5);
      goIdle();
      applyStimulus(1, 1'b0, 16'h0040, 16'h0000);
      goIdle();
      applyStimulus(1, 1'b0, 16'h0041, 16'h0000);
      goIdle();

      // Randomized traffic over a small index window so reads hit earlier writes.
      for (int n = 0; n < 40; n++) begin
         a      = 16'($urandom);
         a[8:1] = 8'($urandom_range(0, 15));
         a[0]   = ($urandom_range(0, 7) == 0);
         applyStimulus(0, 1'($urandom), a, 16'($urandom));
         if ($urandom_range(0, 1) == 1) goIdle();
      end
      goIdle();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
